wb_regfile_slave: RTL
=====================

# wb_regfile_slave

Wishbone B4 classic-cycle slave exposing `NUM_REGS` 32-bit read/write registers with byte-lane writes, a programmable number of wait states and error termination for unmapped addresses. It is the responder counterpart to the team's Wishbone initiators and sits on the shared bus as a generic control/status register bank.

## Interface
- `NUM_REGS`, 6, number of implemented 32-bit registers, word addresses 0..NUM_REGS-1; must satisfy 1 <= NUM_REGS <= 2^ADDR_W
- `ADDR_W`, 3, width of the word address `adr_i`
- `WAIT_STATES`, 2, wait cycles inserted before termination, range 0..255
- `RESET_VAL`, 32'h0000_0000, reset value of every register
- `clk_i`  in  1  single clock; all logic on its rising edge
- `rst_i`  in  1  reset, asynchronous and active-high
- `cyc_i`  in  1  bus cycle in progress
- `stb_i`  in  1  strobe, valid transfer request
- `we_i`  in  1  1 = write, 0 = read
- `adr_i`  in  ADDR_W  word address
- `dat_i`  in  32  write data
- `sel_i`  in  4  byte-lane enables; bit n covers dat[8n+7:8n]
- `dat_o`  out  32  read data; valid only while `ack_o`=1, otherwise 0
- `ack_o`  out  1  normal termination, one cycle per transfer
- `err_o`  out  1  error termination (adr_i >= NUM_REGS), one cycle per transfer

## Operation
- Reset (async, any state): state IDLE, wait counter 0, all registers = RESET_VAL, `ack_o`=0, `err_o`=0, `dat_o`=0. Outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, WAIT, TERM.
- IDLE: at an edge with `cyc_i`&`stb_i`=1, latch `we_i`, `adr_i`, `dat_i`, `sel_i`. If WAIT_STATES=0 go TERM directly (perform termination actions), else go WAIT with counter = WAIT_STATES-1.
- WAIT: at each edge, if `cyc_i`&`stb_i`=0 → abort: IDLE, no register change, no termination. Else if counter=0 → TERM with termination actions; else decrement counter.
- Termination actions (single edge): if latched address >= NUM_REGS → `err_o`=1, `dat_o`=0, no register change. Otherwise `ack_o`=1; read: `dat_o` = register[addr]; write: for each set `sel` bit update that byte lane only, `dat_o`=0.
- TERM: `ack_o` or `err_o` high for exactly this one cycle; next edge unconditionally → IDLE, clearing `ack_o`, `err_o`, `dat_o`. Request inputs are not sampled in TERM.
- `ack_o` and `err_o` are never both 1.
- Write with `sel_i`=4'b0000 is acknowledged and changes nothing.
- Reads ignore `sel_i` and return the full word.
- Inputs sampled only at the IDLE acceptance edge. Changes to `adr_i`/`dat_i`/`we_i`/`sel_i` during WAIT have no effect.

## Timing
- Acceptance edge E0 (IDLE, cyc&stb=1). Termination asserted after edge E0+WAIT_STATES, i.e. visible WAIT_STATES+1 cycles after the request is first presented.
- A write is visible to any subsequent read: the register updates at the same edge that raises `ack_o`.
- After TERM the block spends at least one cycle in IDLE. With `stb_i` held high the next transfer is accepted at the edge leaving IDLE, giving a minimum transfer spacing of WAIT_STATES+2 cycles.
- Abort takes effect at the first WAIT edge where cyc&stb=0. If the request is dropped during TERM, the termination still completes its single cycle.
- Reset asserted mid-transfer clears everything immediately, with no termination. A write not yet in TERM is discarded.

## Test plan
- Reset values: after reset, read addresses 0..5 with WAIT_STATES=2 → each `ack_o` appears 3 cycles after stb and `dat_o`=32'h0; `err_o` stays 0.
- Write/readback: write 32'hDEAD_BEEF to adr 3 with sel 4'hF, then read adr 3 → `dat_o`=32'hDEAD_BEEF. Write adr 3 with data 32'h1122_3344 and sel 4'b0101, then read → 32'hDE22_BE44.
- Error: read adr 6 and write adr 7 → `err_o`=1 for exactly one cycle, `ack_o`=0, `dat_o`=0; registers unchanged, confirmed by readback of adr 0..5.
- Abort: start a write of 32'h5555_5555 to adr 1, drop `stb_i` after 1 cycle of WAIT → no `ack_o`/`err_o`; subsequent read of adr 1 returns the prior value.
- Zero wait and back-to-back, with WAIT_STATES=0: hold cyc/stb high across 4 reads → `ack_o` pulses on alternate cycles (spacing 2), each exactly one cycle wide.
- Async reset mid-transfer: assert `rst_i` between clock edges during WAIT of a write to adr 2 → `ack_o`, `err_o` and `dat_o` drop to 0 immediately without a clock edge; after release, adr 2 reads RESET_VAL.

Source files
------------

// File: rtl/wb_regfile_slave_if.sv
// Wishbone B4 classic-cycle bus bundle for the register-file slave.
// Master drives the request side; slave returns data and terminations.
interface wb_regfile_slave_if #(
  parameter int ADDR_W = 3
);
  logic              cyc_i;
  logic              stb_i;
  logic              we_i;
  logic [ADDR_W-1:0] adr_i;
  logic [31:0]       dat_i;
  logic [3:0]        sel_i;
  logic [31:0]       dat_o;
  logic              ack_o;
  logic              err_o;

  modport master (
    output cyc_i, stb_i, we_i,
    output adr_i, dat_i, sel_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i,
    input  adr_i, dat_i, sel_i,
    output dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb_regfile_slave.sv
// Wishbone classic slave: NUM_REGS x 32-bit byte-lane registers,
// programmable wait states, error termination on unmapped words.
module wb_regfile_slave #(
  parameter int          NUM_REGS    = 6,
  parameter int          ADDR_W      = 3,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic clk_i,
  input  logic rst_i,
  wb_regfile_slave_if.slave wb
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_TERM
  } state_t;

  localparam logic [7:0] WS_M1 =
    (WAIT_STATES == 0) ? 8'd0 : 8'(WAIT_STATES - 1);

  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic req, term, hit, bypass;

  logic              l_we;
  logic [ADDR_W-1:0] l_adr;
  logic [31:0]       l_dat;
  logic [3:0]        l_sel;

  logic              t_we;
  logic [ADDR_W-1:0] t_adr;
  logic [31:0]       t_dat;
  logic [3:0]        t_sel;
  logic [31:0]       rd_dat;

  logic [31:0] regs [NUM_REGS];

  assign req = wb.cyc_i & wb.stb_i;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    term    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_n = S_TERM;
            term    = 1'b1;
          end else begin
            state_n = S_WAIT;
            cnt_n   = WS_M1;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_n = S_IDLE;
        end else if (cnt == 8'd0) begin
          state_n = S_TERM;
          term    = 1'b1;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_TERM:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Zero-wait terminations happen on the acceptance edge itself,
  // so they must use the live request rather than the latched copy.
  assign bypass = (state == S_IDLE);
  assign t_we   = bypass ? wb.we_i  : l_we;
  assign t_adr  = bypass ? wb.adr_i : l_adr;
  assign t_dat  = bypass ? wb.dat_i : l_dat;
  assign t_sel  = bypass ? wb.sel_i : l_sel;

  assign hit    = 32'(t_adr) < 32'(NUM_REGS);
  assign rd_dat = hit ? regs[t_adr] : 32'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      l_we     <= 1'b0;
      l_adr    <= '0;
      l_dat    <= 32'h0;
      l_sel    <= 4'h0;
      wb.ack_o <= 1'b0;
      wb.err_o <= 1'b0;
      wb.dat_o <= 32'h0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_VAL;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wb.ack_o <= term & hit;
      wb.err_o <= term & ~hit;
      wb.dat_o <= (term & hit & ~t_we) ? rd_dat : 32'h0;
      if (state == S_IDLE && req) begin
        l_we  <= wb.we_i;
        l_adr <= wb.adr_i;
        l_dat <= wb.dat_i;
        l_sel <= wb.sel_i;
      end
      if (term && hit && t_we) begin
        for (int b = 0; b < 4; b++)
          if (t_sel[b])
            regs[t_adr][8*b +: 8] <= t_dat[8*b +: 8];
      end
    end
  end

endmodule
